aibcr3_rxdeser: RTL and testbench

AIBCR3_RXDESER -- requirements
Module: aibcr3_rxdeser

---
 rtl/aibcr3_rxdeser_pkg.sv | 20 ++
 rtl/aibcr3_rxdeser_align.sv | 90 +++++++++
 rtl/aibcr3_rxdeser.sv | 94 +++++++++
 tb/tb_aibcr3_rxdeser.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3_rxdeser_pkg.sv
// Shared types and marker geometry for the DDR receive deserializer.
// The marker bits are only consulted when AIBCR3_RXDESER_MARK_EN is defined.
package aibcr3_rxdeser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // The marker is a 1 in the word MSB and a 0 in the MSB of the low half.
    function automatic int mark_hi(input int dw);
        return dw - 1;
    endfunction

    function automatic int mark_lo(input int dw);
        return dw / 2 - 1;
    endfunction

endpackage

// File: rtl/aibcr3_rxdeser_align.sv
// Word-alignment FSM: hunts for the marker, slips on miss, holds lock.
// Compiled into the top only when AIBCR3_RXDESER_MARK_EN is defined.
module aibcr3_rxdeser_align
    import aibcr3_rxdeser_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_CNT  = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_bnd,
    input  logic i_match,
    output logic o_lock_nxt,
    output logic o_slip
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(ERR_CNT + 1);

    state_t          r_state;
    logic [GW-1:0]   r_good;
    logic [BW-1:0]   r_bad;
    logic            r_slip;

    state_t          w_state;
    logic [GW-1:0]   w_good;
    logic [BW-1:0]   w_bad;
    logic            w_slip;

    always_comb begin
        w_state = r_state;
        w_good  = r_good;
        w_bad   = r_bad;
        w_slip  = 1'b0;
        if (!i_en) begin
            w_state = ST_IDLE;
            w_good  = '0;
            w_bad   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state = ST_HUNT;
                ST_HUNT: begin
                    if (i_bnd && i_match) begin
                        if (r_good == GW'(LOCK_CNT - 1)) begin
                            w_state = ST_LOCK;
                            w_good  = '0;
                        end else begin
                            w_good = r_good + 1'b1;
                        end
                    end else if (i_bnd) begin
                        w_good = '0;
                        w_slip = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (i_bnd && i_match) begin
                        w_bad = '0;
                    end else if (i_bnd) begin
                        if (r_bad == BW'(ERR_CNT - 1)) begin
                            w_state = ST_HUNT;
                            w_bad   = '0;
                        end else begin
                            w_bad = r_bad + 1'b1;
                        end
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_good  <= '0;
            r_bad   <= '0;
            r_slip  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_good  <= w_good;
            r_bad   <= w_bad;
            r_slip  <= w_slip;
        end
    end

    assign o_lock_nxt = (w_state == ST_LOCK);
    assign o_slip     = r_slip;

endmodule

// File: rtl/aibcr3_rxdeser.sv
// DDR pair deserializer; marker alignment with AIBCR3_RXDESER_MARK_EN,
// otherwise free-running word framing that locks on the first word.
module aibcr3_rxdeser
    import aibcr3_rxdeser_pkg::*;
#(
    parameter int DWIDTH   = 20,
    parameter int LOCK_CNT = 4,
    parameter int ERR_CNT  = 4
) (
    input  logic              istrbclk,
    input  logic              irstb,
    input  logic              rx_en,
    input  logic              odat0,
    input  logic              odat1,
    output logic [DWIDTH-1:0] rx_word,
    output logic              rx_word_vld,
    output logic              rx_locked
);

    localparam int NPAIR = DWIDTH / 2;
    localparam int PW    = $clog2(NPAIR);
    localparam logic [PW-1:0] P_LAST = PW'(NPAIR - 1);

    logic [DWIDTH-1:0] r_sr;
    logic [PW-1:0]     r_pcnt;
    logic [DWIDTH-1:0] r_word;
    logic              r_vld;
    logic              r_locked;

    logic [DWIDTH-1:0] w_word;
    logic              w_bnd;
    logic              w_lock_nxt;
    logic              w_slip;

    assign w_word = {odat1, odat0, r_sr[DWIDTH-1:2]};
    assign w_bnd  = rx_en && (r_pcnt == P_LAST);

`ifdef AIBCR3_RXDESER_MARK_EN
    localparam int MHI = mark_hi(DWIDTH);
    localparam int MLO = mark_lo(DWIDTH);

    logic w_match;
    assign w_match = w_word[MHI] & ~w_word[MLO];

    aibcr3_rxdeser_align #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_CNT  (ERR_CNT)
    ) u_align (
        .i_clk      (istrbclk),
        .i_rst_n    (irstb),
        .i_en       (rx_en),
        .i_bnd      (w_bnd),
        .i_match    (w_match),
        .o_lock_nxt (w_lock_nxt),
        .o_slip     (w_slip)
    );
`else
    assign w_slip     = 1'b0;
    assign w_lock_nxt = rx_en & (r_locked | w_bnd);
`endif

    always_ff @(posedge istrbclk or negedge irstb) begin
        if (!irstb) begin
            r_sr     <= '0;
            r_pcnt   <= '0;
            r_word   <= '0;
            r_vld    <= 1'b0;
            r_locked <= 1'b0;
        end else if (!rx_en) begin
            r_sr     <= '0;
            r_pcnt   <= '0;
            r_vld    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_sr <= w_word;
            // A slip re-uses pair slot 0, pushing the next boundary out a pair.
            if (w_slip)
                r_pcnt <= r_pcnt;
            else if (w_bnd)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 1'b1;
            if (w_bnd)
                r_word <= w_word;
            r_vld    <= w_bnd & w_lock_nxt;
            r_locked <= w_lock_nxt;
        end
    end

    assign rx_word     = r_word;
    assign rx_word_vld = r_vld;
    assign rx_locked   = r_locked;

endmodule

// File: tb/tb_aibcr3_rxdeser.sv
// Directed bench for aibcr3_rxdeser; adapts to AIBCR3_RXDESER_MARK_EN.
// Table of streams plus reset, enable-drop and lock-loss sequences.
module tb_aibcr3_rxdeser;

    localparam int DW = 20;
    localparam int NP = DW / 2;
`ifdef AIBCR3_RXDESER_MARK_EN
    localparam int LW = 4;
`else
    localparam int LW = 1;
`endif

    logic          istrbclk = 1'b0;
    logic          irstb    = 1'b0;
    logic          rx_en    = 1'b0;
    logic          odat0    = 1'b0;
    logic          odat1    = 1'b0;
    logic [DW-1:0] rx_word;
    logic          rx_word_vld;
    logic          rx_locked;

    aibcr3_rxdeser #(
        .DWIDTH   (DW),
        .LOCK_CNT (4),
        .ERR_CNT  (4)
    ) dut (
        .istrbclk    (istrbclk),
        .irstb       (irstb),
        .rx_en       (rx_en),
        .odat0       (odat0),
        .odat1       (odat1),
        .rx_word     (rx_word),
        .rx_word_vld (rx_word_vld),
        .rx_locked   (rx_locked)
    );

    always #5 istrbclk = ~istrbclk;

    int            npass = 0;
    int            ntot  = 0;
    int            cyc_n;
    int            nvld;
    int            first_vld;
    int            nbadw;
    int            nconsec;
    logic          prev_vld = 1'b0;
    logic [DW-1:0] exp_w;

    typedef struct {
        logic [DW-1:0] word;
        int            lag;
        int            nw;
        int            first;
        int            nv;
        logic          lock;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input longint got, input longint exp);
        ntot++;
        if (got == exp)
            npass++;
        else
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, got, got, exp, exp);
    endtask

    task automatic cyc(input logic en, input logic b0, input logic b1);
        rx_en = en;
        odat0 = b0;
        odat1 = b1;
        @(posedge istrbclk);
        #1;
        if (rx_word_vld) begin
            if (first_vld < 0)
                first_vld = cyc_n;
            nvld++;
            if (rx_word !== exp_w)
                nbadw++;
            if (prev_vld)
                nconsec++;
        end
        prev_vld = rx_word_vld;
        cyc_n++;
    endtask

    task automatic clear_log(input logic [DW-1:0] w);
        exp_w     = w;
        cyc_n     = 0;
        nvld      = 0;
        first_vld = -1;
        nbadw     = 0;
        nconsec   = 0;
    endtask

    task automatic flush();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < NP; i++)
            cyc(1'b1, w[2*i], w[2*i+1]);
    endtask

    task automatic send_pairs(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, w[2*i], w[2*i+1]);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef AIBCR3_RXDESER_MARK_EN
        vt[0] = '{20'h8A1F5, 0, 7, 39, 4, 1'b1};
        vt[1] = '{20'h80000, 3, 9, 72, 3, 1'b1};
        vt[2] = '{20'h00001, 0, 6, -1, 0, 1'b0};
        vt[3] = '{20'hFFDFF, 1, 8, 50, 4, 1'b1};
`else
        vt[0] = '{20'h00001, 0, 5, 9, 5, 1'b1};
        vt[1] = '{20'h8A1F5, 0, 3, 9, 3, 1'b1};
        vt[2] = '{20'hFFFFF, 0, 2, 9, 2, 1'b1};
        vt[3] = '{20'h80000, 0, 4, 9, 4, 1'b1};
`endif

        repeat (2) @(posedge istrbclk);
        #1;
        chk("rst_word", rx_word, 0);
        chk("rst_vld", rx_word_vld, 0);
        chk("rst_locked", rx_locked, 0);
        #2 irstb = 1'b1;

        for (int i = 0; i < 4; i++) begin
            flush();
            clear_log(vt[i].word);
            send_pairs(20'h00000, vt[i].lag);
            repeat (vt[i].nw) send_word(vt[i].word);
            chk($sformatf("v%0d_first_vld", i), first_vld, vt[i].first);
            chk($sformatf("v%0d_nvld", i), nvld, vt[i].nv);
            chk($sformatf("v%0d_bad_words", i), nbadw, 0);
            chk($sformatf("v%0d_consec_vld", i), nconsec, 0);
            chk($sformatf("v%0d_locked", i), rx_locked, vt[i].lock);
        end

        // asynchronous reset while locked, between clock edges
        flush();
        clear_log(20'h8A1F5);
        repeat (LW + 1) send_word(20'h8A1F5);
        chk("pre_rst_vld", rx_word_vld, 1);
        #2 irstb = 1'b0;
        #1;
        chk("async_rst_word", rx_word, 0);
        chk("async_rst_vld", rx_word_vld, 0);
        chk("async_rst_locked", rx_locked, 0);
        #2 irstb = 1'b1;

        // rx_en dropped in pair slot 5 while locked, then relock
        flush();
        clear_log(20'h8A1F5);
        repeat (LW) send_word(20'h8A1F5);
        chk("en_pre_locked", rx_locked, 1);
        send_pairs(20'h12345, 5);
        cyc(1'b0, 1'b1, 1'b1);
        chk("en_drop_vld", rx_word_vld, 0);
        chk("en_drop_locked", rx_locked, 0);
        chk("en_drop_word_hold", rx_word, 20'h8A1F5);
        clear_log(20'h8A1F5);
        repeat (LW + 1) send_word(20'h8A1F5);
        chk("relock_first_vld", first_vld, 10 * LW - 1);
        chk("relock_locked", rx_locked, 1);
        chk("relock_nvld", nvld, 2);

`ifdef AIBCR3_RXDESER_MARK_EN
        // three bad words keep lock, four drop it
        flush();
        clear_log(20'h8A1F5);
        repeat (4) send_word(20'h8A1F5);
        chk("bad_pre_locked", rx_locked, 1);
        clear_log(20'h00000);
        repeat (3) send_word(20'h00000);
        chk("bad3_nvld", nvld, 3);
        chk("bad3_words", nbadw, 0);
        chk("bad3_locked", rx_locked, 1);
        clear_log(20'h8A1F5);
        send_word(20'h8A1F5);
        chk("good_after_bad_nvld", nvld, 1);
        chk("good_after_bad_locked", rx_locked, 1);
        clear_log(20'h00000);
        repeat (4) send_word(20'h00000);
        chk("bad4_nvld", nvld, 3);
        chk("bad4_consec", nconsec, 0);
        chk("bad4_locked", rx_locked, 0);
`else
        // without alignment, a word lacking any marker still frames and locks
        flush();
        clear_log(20'h00000);
        send_pairs(20'h00000, NP - 1);
        chk("nm_pre_locked", rx_locked, 0);
        send_pairs(20'h00000, 1);
        chk("nm_first_locked", rx_locked, 1);
        chk("nm_first_vld", rx_word_vld, 1);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
